seq_multiplier: RTL

Unsigned sequential shift-and-add multiplier built around the ALU's WIDTH-bit ripple-carry adder (`full_adder`, instantiated inside this block). It sits in the ALU datapath as the multi-cycle multiply unit. It accepts one operand pair through a valid/ready handshake and runs one add-and-shift step per clock through the adder. It returns the full 2×WIDTH-bit product through a second valid/ready handshake.

---
 rtl/seq_multiplier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one ripple-carry add plus a right shift per clock,
// full 2*WIDTH-bit product returned through a valid/ready handshake.

module full_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

module seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Low half of ACC holds the not-yet-consumed multiplier bits; ACC[0] selects the addend.
    assign add_b = acc_q[0] ? m_q : '0;

    full_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_d     = in_a;
                    acc_d   = {{WIDTH{1'b0}}, in_b};
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy  = 1'b1;
                // Carry-out lands in the top bit so the partial product never loses a bit.
                acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_product = acc_q;

endmodule
